// File: rtl/passcode_ctrl.sv
// Passcode lock sequencer: captures keypad digits through an external encoder,
// stores/compares the encoded code, counts failed attempts and times a lockout.
module passcode_ctrl #(
  parameter int DIGITS      = 4,
  parameter int CODE_W      = 5,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [3:0]        key_digit,
  input  logic              key_enter,
  input  logic              key_clear,
  input  logic              set_mode,
  output logic [3:0]        enc_in,
  input  logic [CODE_W-1:0] enc_out,
  output logic              unlock,
  output logic              fail,
  output logic              alarm,
  output logic              need_setup,
  output logic [2:0]        digit_cnt,
  output logic              key_err,
  output logic [2:0]        dbg_state
);

  localparam int ENTRY_W = DIGITS * CODE_W;
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int TMR_W   = $clog2(LOCK_CYCLES);

  typedef enum logic [2:0] {
    S_SETUP   = 3'd0,
    S_IDLE    = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t             state, state_d;
  logic [ENTRY_W-1:0] entry, entry_d, stored, stored_d;
  logic               pw_valid, pw_valid_d;
  logic [TRY_W-1:0]   tries, tries_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [2:0]         cnt_d;
  logic               key_err_d;
  logic               cnt_full, digit_ok, match;
  logic [ENTRY_W-1:0] entry_shift;

  // Key strobes are single-cycle pulses sampled every clock with no back-pressure;
  // within one cycle key_clear beats key_enter beats key_valid, losers are dropped.
  assign enc_in      = key_digit;
  assign dbg_state   = state;
  assign cnt_full    = (digit_cnt == 3'(DIGITS));
  assign digit_ok    = (key_digit <= 4'd9);
  assign match       = pw_valid && cnt_full && (entry == stored);
  assign entry_shift = {entry[ENTRY_W-CODE_W-1:0], enc_out};

  always_comb begin
    state_d    = state;
    entry_d    = entry;
    stored_d   = stored;
    pw_valid_d = pw_valid;
    tries_d    = tries;
    timer_d    = timer;
    cnt_d      = digit_cnt;
    key_err_d  = 1'b0;
    case (state)
      S_SETUP, S_IDLE: begin
        if (key_clear) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (key_enter) begin
          if (state == S_IDLE) begin
            state_d = S_CHECK;
          end else begin
            if (cnt_full) begin
              stored_d   = entry;
              pw_valid_d = 1'b1;
              state_d    = S_IDLE;
            end
            entry_d = '0;
            cnt_d   = '0;
          end
        end else if (key_valid) begin
          if (digit_ok && !cnt_full) begin
            entry_d = entry_shift;
            cnt_d   = digit_cnt + 3'd1;
          end else begin
            key_err_d = 1'b1;
          end
        end
      end
      S_CHECK: begin
        entry_d = '0;
        cnt_d   = '0;
        if (match) begin
          tries_d = '0;
          state_d = S_OPEN;
        end else if (int'(tries) + 1 >= MAX_TRIES) begin
          timer_d = TMR_W'(LOCK_CYCLES - 1);
          state_d = S_LOCKOUT;
        end else begin
          tries_d = tries + TRY_W'(1);
          state_d = S_FAIL;
        end
      end
      S_OPEN: begin
        // The old code stays live in SETUP until a full new entry is committed.
        if (key_clear)     state_d = S_IDLE;
        else if (set_mode) state_d = S_SETUP;
      end
      S_FAIL: state_d = S_IDLE;
      S_LOCKOUT: begin
        if (timer == '0) begin
          tries_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer - TMR_W'(1);
        end
      end
      default: state_d = S_SETUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_SETUP;
      entry      <= '0;
      stored     <= '0;
      pw_valid   <= 1'b0;
      tries      <= '0;
      timer      <= '0;
      digit_cnt  <= '0;
      key_err    <= 1'b0;
      unlock     <= 1'b0;
      fail       <= 1'b0;
      alarm      <= 1'b0;
      need_setup <= 1'b1;
    end else begin
      state      <= state_d;
      entry      <= entry_d;
      stored     <= stored_d;
      pw_valid   <= pw_valid_d;
      tries      <= tries_d;
      timer      <= timer_d;
      digit_cnt  <= cnt_d;
      key_err    <= key_err_d;
      unlock     <= (state == S_OPEN);
      fail       <= (state == S_FAIL);
      alarm      <= (state == S_LOCKOUT);
      need_setup <= (state == S_SETUP);
    end
  end

endmodule
